// File: rtl/tdm_demux4_pkg.sv
// Shared TDM definitions for the 4-channel mux/demux pair.
// Channel count, slot index width and the demux framing state enum.
package tdm_pkg;

    localparam int NCH    = 4;
    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux4_if.sv
// TDM stream bus for tdm_demux4: serial input beats plus the rebuilt
// parallel frame and framing status. The master drives the stream,
// the slave (the demux) drives the frame/status signals.
interface tdm_demux4_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic                   in_valid;
    logic                   in_sof;
    logic [WIDTH-1:0]       in_data;
    logic [NCH*WIDTH-1:0]   out_data;
    logic                   out_valid;
    slot_t                  slot;
    logic                   locked;
    logic                   frame_err;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_data, out_valid, slot, locked, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_data, out_valid, slot, locked, frame_err
    );

endinterface

// File: rtl/tdm_demux4_slot_counter.sv
// Slot index counter for the TDM demux: clear has priority over load-1,
// which has priority over increment; increment wraps 3 -> 0.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  load1,
    input  logic  inc,
    output slot_t slot
);

    // Slot register: synchronous reset, then clear/load/increment in priority order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= slot + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: rebuilds four parallel channel words from a TDM stream of one
// sample per beat (slot 0 flagged by in_sof) and strobes each complete frame.
// Optional macro TDM_DEMUX_FRAME_CNT_EN adds a 16-bit wrapping frame counter.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux4_if.slave    bus
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt
`endif
);

    state_t             state_q, state_d;
    slot_t              slot_q;
    logic               slot_clr, slot_load1, slot_inc;
    logic               wr_en;
    slot_t              wr_idx;
    logic               commit, err;
    logic [WIDTH-1:0]   shadow_q [0:NCH-2];
    logic [NCH*WIDTH-1:0] out_data_q;
    logic               out_valid_q, frame_err_q;

    tdm_slot_counter u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (slot_clr),
        .load1 (slot_load1),
        .inc   (slot_inc),
        .slot  (slot_q)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    // Next-state, slot control, shadow write and frame/error decisions for the current beat.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        slot_clr   = 1'b0;
        slot_load1 = 1'b0;
        slot_inc   = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = slot_q;
        commit     = 1'b0;
        err        = 1'b0;
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.in_sof) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        slot_load1 = 1'b1;
                        state_d    = SYNC;
                    end
                end
                SYNC: begin
                    if (bus.in_sof) begin
                        // A start mid-frame abandons the partial frame and restarts at slot 0.
                        err        = (slot_q != '0);
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        slot_load1 = 1'b1;
                    end else if (slot_q == '0) begin
                        // Slot 0 without a start marker means alignment is lost.
                        err        = 1'b1;
                        slot_clr   = 1'b1;
                        state_d    = HUNT;
                    end else if (slot_q == SLOT_W'(NCH-1)) begin
                        commit     = 1'b1;
                        slot_clr   = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        slot_inc   = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Shadow capture of slots 0..2 and atomic frame copy to the output register.
    // NOTE: shadow registers are reset too, so a frame cut by reset can never leak old samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH-1; i++) shadow_q[i] <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH-1; i++) begin
                if (wr_en && wr_idx == SLOT_W'(i)) shadow_q[i] <= bus.in_data;
            end
            if (commit) out_data_q <= {bus.in_data, shadow_q[2], shadow_q[1], shadow_q[0]};
            out_valid_q <= commit;
            frame_err_q <= err;
        end
    end

`ifdef TDM_DEMUX_FRAME_CNT_EN
    // Frame counter advances together with each out_valid strobe, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n)      frame_cnt <= '0;
        else if (commit) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.slot      = slot_q;
    assign bus.locked    = (state_q == SYNC);

endmodule
